// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared bus widths and responder state encoding
package mem_responder_pkg;

    localparam int BUSWIDTH        = 16;
    localparam int DATAPAYLOADSIZE = 4;
    localparam int OFFW            = 12;

    typedef enum logic [3:0] {
        IDLE,
        RD0, RD1, RD2, RD3,
        WR0, WR1, WR2, WR3,
        DONE
    } mem_resp_state_t;

    // Word index within the burst implied by the current data state.
    function automatic logic [1:0] state_offset(input mem_resp_state_t s);
        case (s)
            RD1, WR1: return 2'd1;
            RD2, WR2: return 2'd2;
            RD3, WR3: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - main bus signals shared by master and responder
interface mem_responder_if;
    import mem_responder_pkg::*;

    tri   [BUSWIDTH-1:0] AddrData;
    logic                AddrValid;
    logic                rw;
    logic                busy;
    logic                done;
    logic                err;

    modport slave (
        inout  AddrData,
        input  AddrValid,
        input  rw,
        output busy,
        output done,
        output err
    );

    modport master (
        inout  AddrData,
        output AddrValid,
        output rw,
        input  busy,
        input  done,
        input  err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - one page of storage, async read, sync write
module mem_array
    import mem_responder_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [OFFW-1:0]     wr_addr,
    input  logic [BUSWIDTH-1:0] wr_data,
    input  logic [OFFW-1:0]     rd_addr,
    output logic [BUSWIDTH-1:0] rd_data
);

    logic [BUSWIDTH-1:0] mem [0:(1<<OFFW)-1];

    // Contents survive reset on purpose, so there is no reset branch here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 4-word burst page responder; MEMRESP_ALIGN_CHECK_EN enables alignment errors
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [3:0] PAGE = 4'h0
) (
    input  logic         clk,
    input  logic         resetL,
    mem_responder_if.slave bus
);

    mem_resp_state_t     state, state_nxt;
    logic [OFFW-1:0]     base_q;
    logic [OFFW-1:0]     mem_addr;
    logic [BUSWIDTH-1:0] rd_word;
    logic [1:0]          offset;
    logic                page_hit;
    logic                misaligned;
    logic                start;
    logic                drive_en;
    logic                wr_en;

    assign page_hit = bus.AddrValid && (bus.AddrData[15:12] == PAGE);

`ifdef MEMRESP_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = (bus.AddrData[1:0] != 2'b00);

    // Rejected bursts report in the cycle after their address phase.
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && page_hit && misaligned;
        end
    end

    assign bus.err = err_q;
`else
    assign misaligned = 1'b0;
    assign bus.err    = 1'b0;
`endif

    assign start = page_hit && !misaligned;

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            base_q <= '0;
        end else if ((state == IDLE) && start) begin
            base_q <= bus.AddrData[OFFW-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = bus.rw ? RD0 : WR0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = RD3;
            RD3:     state_nxt = DONE;
            WR0:     state_nxt = WR1;
            WR1:     state_nxt = WR2;
            WR2:     state_nxt = WR3;
            WR3:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        drive_en = 1'b0;
        wr_en    = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        offset   = state_offset(state);
        case (state)
            RD0, RD1, RD2, RD3: begin
                drive_en = 1'b1;
                bus.busy = 1'b1;
            end
            WR0, WR1, WR2, WR3: begin
                wr_en    = 1'b1;
                bus.busy = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // 12-bit add wraps inside the page; the page field is never touched.
    assign mem_addr = base_q + {{(OFFW-2){1'b0}}, offset};

    mem_array u_mem_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (mem_addr),
        .wr_data (bus.AddrData),
        .rd_addr (mem_addr),
        .rd_data (rd_word)
    );

    assign bus.AddrData = drive_en ? rd_word : {BUSWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (PAGE=2)
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam logic [3:0]          PAGE_T = 4'h2;
    localparam logic [BUSWIDTH-1:0] SENT   = 16'h0000;

    logic clk;
    logic resetL;
    logic tb_en;
    logic [BUSWIDTH-1:0] tb_val;

    int n_tests;
    int n_fail;

    logic [BUSWIDTH-1:0] model_mem [0:4095];
    logic [BUSWIDTH-1:0] exp_q [$];

    mem_responder_if bus ();

    assign bus.AddrData = tb_en ? tb_val : {BUSWIDTH{1'bz}};

    mem_responder #(.PAGE(PAGE_T)) dut (
        .clk    (clk),
        .resetL (resetL),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_hit(input logic [3:0] page, input logic [11:0] base);
`ifdef MEMRESP_ALIGN_CHECK_EN
        return (page == PAGE_T) && (base[1:0] == 2'b00);
`else
        return (page == PAGE_T);
`endif
    endfunction

    function automatic logic exp_err(input logic [3:0] page, input logic [11:0] base);
`ifdef MEMRESP_ALIGN_CHECK_EN
        return (page == PAGE_T) && (base[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic addr_phase(input logic rd, input logic [3:0] page, input logic [11:0] base);
        tick();
        bus.AddrValid = 1'b1;
        bus.rw        = rd;
        tb_en         = 1'b1;
        tb_val        = {page, base};
        @(negedge clk);
        check("t0_busy", {15'd0, bus.busy}, 16'd0);
    endtask

    task automatic data_cycle(input logic hit, input logic rd, input logic [15:0] wdata,
                              input logic first, input logic err_exp);
        logic [15:0] exp;
        tick();
        bus.AddrValid = 1'b0;
        if (hit && rd) begin
            tb_en = 1'b0;
        end else begin
            tb_en  = 1'b1;
            tb_val = hit ? wdata : SENT;
        end
        @(negedge clk);
        check("busy", {15'd0, bus.busy}, {15'd0, hit});
        check("done_in_data", {15'd0, bus.done}, 16'd0);
        if (first) check("err_t1", {15'd0, bus.err}, {15'd0, err_exp});
        if (hit && rd) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 16'd1, 16'd0);
            end else begin
                exp = exp_q.pop_front();
                check("rd_data", bus.AddrData, exp);
            end
        end else begin
            check("bus_owner", bus.AddrData, tb_val);
        end
    endtask

    task automatic done_cycle(input logic hit);
        tick();
        bus.AddrValid = 1'b0;
        tb_en  = 1'b1;
        tb_val = SENT;
        @(negedge clk);
        check("done_t5", {15'd0, bus.done}, {15'd0, hit});
        check("busy_t5", {15'd0, bus.busy}, 16'd0);
        check("bus_t5", bus.AddrData, SENT);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.AddrValid = 1'b0;
            tb_en  = 1'b1;
            tb_val = SENT;
            @(negedge clk);
            check("idle_done", {15'd0, bus.done}, 16'd0);
            check("idle_busy", {15'd0, bus.busy}, 16'd0);
            check("idle_bus", bus.AddrData, SENT);
        end
    endtask

    task automatic burst(input logic rd, input logic [3:0] page, input logic [11:0] base,
                         input logic [63:0] data);
        logic hit;
        logic [11:0] a;
        hit = is_hit(page, base);
        for (int n = 0; n < DATAPAYLOADSIZE; n++) begin
            a = base + 12'(n);
            if (hit && rd)  exp_q.push_back(model_mem[a]);
            if (hit && !rd) model_mem[a] = data[16*n +: 16];
        end
        addr_phase(rd, page, base);
        for (int n = 0; n < DATAPAYLOADSIZE; n++) begin
            data_cycle(hit, rd, data[16*n +: 16], n == 0, exp_err(page, base));
        end
        done_cycle(hit);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        resetL        = 1'b0;
        tb_en         = 1'b1;
        tb_val        = SENT;
        bus.AddrValid = 1'b0;
        bus.rw        = 1'b0;

        #2;
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_done", {15'd0, bus.done}, 16'd0);
        check("rst_err",  {15'd0, bus.err},  16'd0);
        check("rst_bus",  bus.AddrData, SENT);
        tick();
        tick();
        resetL = 1'b1;
        idle(1);

        // Basic write then read-back.
        burst(1'b0, PAGE_T, 12'h010, 64'h4444_3333_2222_1111);
        idle(1);
        burst(1'b1, PAGE_T, 12'h010, 64'h0);
        idle(1);

        // Other page is ignored entirely.
        burst(1'b1, 4'h5, 12'h010, 64'h0);
        idle(1);
        burst(1'b0, 4'h5, 12'h010, 64'hDEAD_BEEF_CAFE_F00D);
        idle(1);
        burst(1'b1, PAGE_T, 12'h010, 64'h0);
        idle(1);

        // Offset wraps inside the page.
        burst(1'b0, PAGE_T, 12'h000, 64'h1004_1003_1002_1001);
        idle(1);
        burst(1'b0, PAGE_T, 12'hFFE, 64'h000D_000C_000B_000A);
        idle(1);
        burst(1'b1, PAGE_T, 12'hFFE, 64'h0);
        idle(1);
        burst(1'b1, PAGE_T, 12'h000, 64'h0);
        idle(1);

        // Reset in the middle of a read burst.
        for (int n = 0; n < DATAPAYLOADSIZE; n++) exp_q.push_back(model_mem[12'h010 + 12'(n)]);
        addr_phase(1'b1, PAGE_T, 12'h010);
        data_cycle(1'b1, 1'b1, 16'h0, 1'b1, 1'b0);
        data_cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        data_cycle(1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        #2;
        resetL = 1'b0;
        tb_en  = 1'b1;
        tb_val = SENT;
        #1;
        check("midrst_busy", {15'd0, bus.busy}, 16'd0);
        check("midrst_bus",  bus.AddrData, SENT);
        exp_q.delete();
        tick();
        tick();
        resetL = 1'b1;
        idle(1);
        burst(1'b1, PAGE_T, 12'h010, 64'h0);
        idle(1);

        // Back-to-back: read address phase lands in T6 of the write.
        burst(1'b0, PAGE_T, 12'h100, 64'h7777_6666_5555_5A5A);
        burst(1'b1, PAGE_T, 12'h100, 64'h0);
        idle(1);

        // Misaligned base: rejected only when the alignment check is built in.
        burst(1'b0, PAGE_T, 12'h004, 64'h0B08_0B07_0B06_0B05);
        idle(1);
        burst(1'b0, PAGE_T, 12'h003, 64'h0E0E_0D0D_0C0C_0B0B);
        idle(1);
        burst(1'b1, PAGE_T, 12'h000, 64'h0);
        idle(1);
        burst(1'b1, PAGE_T, 12'h004, 64'h0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
